// File: rtl/checker_pkg.sv
// Shared definitions for the vector response checker: FSM encoding and the
// default expected-response table (odd parity of {A,B,C,D}).
package checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_TRUTH_TABLE = 16'h6996;

endpackage

// File: rtl/vector_response_checker_if.sv
// Stimulus-side bundle seen by the checker: the applied vector, its strobe,
// the DUT response F and the end-of-run request.
//
// Handshake: vec_valid is a single-cycle strobe with no ready/backpressure;
// whatever A..D hold on the edge where vec_valid is high is the captured vector.
interface vector_response_checker_if;
    logic vec_valid;
    logic A;
    logic B;
    logic C;
    logic D;
    logic F;
    logic finish;

    modport master (output vec_valid, A, B, C, D, F, finish);
    modport slave  (input  vec_valid, A, B, C, D, F, finish);
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/vector_response_checker.sv
// Captures each strobed vector, waits SETTLE edges, samples F against the
// truth table, and keeps saturating vector/mismatch counts until finish.
module vector_response_checker
    import checker_pkg::*;
#(
    parameter logic [15:0] TRUTH_TABLE = DEFAULT_TRUTH_TABLE,
    parameter int          SETTLE      = 2,
    parameter int          COUNT_W     = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    vector_response_checker_if.slave stim,
    output logic                   busy,
    output logic                   check_done,
    output logic                   mismatch,
    output logic [COUNT_W-1:0]     vec_count,
    output logic [COUNT_W-1:0]     err_count,
    output logic [3:0]             last_fail_vec,
    output logic                   done,
    output logic                   pass,
    output state_t                 state
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam state_t AFTER_CAPTURE = (SETTLE == 0) ? CHECK : WAIT;

    state_t        next_state;
    logic [SW-1:0] settle_q;
    logic [SW-1:0] settle_d;
    logic [3:0]    vec_q;
    logic [3:0]    vec_d;
    logic          do_check;
    logic          is_mismatch;
    logic          accept_finish;
    logic [3:0]    in_vec;

    assign in_vec        = {stim.A, stim.B, stim.C, stim.D};
    assign accept_finish = stim.finish && (state != DONE);
    assign busy          = (state == WAIT) || (state == CHECK);

    always_comb begin
        next_state  = state;
        settle_d    = settle_q;
        vec_d       = vec_q;
        do_check    = 1'b0;
        is_mismatch = 1'b0;
        if (accept_finish) begin
            // An in-flight vector is abandoned: no compare, no pulse.
            next_state = DONE;
        end else begin
            case (state)
                IDLE: begin
                    if (stim.vec_valid) begin
                        vec_d      = in_vec;
                        settle_d   = '0;
                        next_state = AFTER_CAPTURE;
                    end
                end
                WAIT: begin
                    if (stim.vec_valid) begin
                        vec_d    = in_vec;
                        settle_d = '0;
                    end else if (settle_q == SETTLE_LAST) begin
                        next_state = CHECK;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                CHECK: begin
                    do_check = 1'b1;
                    // Case inequality so an X/Z response is reported as a miss.
                    is_mismatch = (stim.F !== TRUTH_TABLE[vec_q]);
                    if (stim.vec_valid) begin
                        vec_d      = in_vec;
                        settle_d   = '0;
                        next_state = AFTER_CAPTURE;
                    end else begin
                        next_state = IDLE;
                    end
                end
                default: begin
                    next_state = DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            settle_q      <= '0;
            vec_q         <= '0;
            check_done    <= 1'b0;
            mismatch      <= 1'b0;
            last_fail_vec <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            state      <= next_state;
            settle_q   <= settle_d;
            vec_q      <= vec_d;
            check_done <= do_check;
            mismatch   <= is_mismatch;
            if (is_mismatch) begin
                last_fail_vec <= vec_q;
            end
            if (accept_finish) begin
                done <= 1'b1;
                pass <= (err_count == '0);
            end
        end
    end

    sat_counter #(.W(COUNT_W)) u_vec_count (
        .clock (clock),
        .reset (reset),
        .inc   (do_check),
        .count (vec_count)
    );

    sat_counter #(.W(COUNT_W)) u_err_count (
        .clock (clock),
        .reset (reset),
        .inc   (is_mismatch),
        .count (err_count)
    );

endmodule
